sound_event_sequencer: RTL and testbench

Upstream stage of the audio path. Turns single-cycle game events (left/right button push, speed-round start, game won) into a timed `sound_type` code plus a `sound_en` gate for the downstream tone generator. The gate is ANDed with the generator's `audio` at the top level. The block arbitrates between simultaneous and overlapping events by priority, plays each sound for a parameterised number of cycles, and sequences a four-step win melody. After a win it stays locked until the next game restart.

---
 rtl/sound_event_sequencer.sv | 105 ++++++++++
 tb/tb_sound_event_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sound_event_sequencer.sv
// Priority arbiter and timer turning single-cycle game events into a timed
// sound code and gate, with a four-step win melody and post-win lock.
module sound_event_sequencer #(
   parameter int unsigned BTN_CYCLES      = 10_000_000,
   parameter int unsigned SPEED_CYCLES    = 50_000_000,
   parameter int unsigned WIN_STEP_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       right_evt,
   input  logic       left_evt,
   input  logic       speed_evt,
   input  logic       win_evt,
   input  logic       game_restart,
   output logic [1:0] sound_type,
   output logic       sound_en,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, PLAY, WIN_SEQ, LOCKED} state_t;

   localparam logic [31:0] BTN_LD   = 32'(BTN_CYCLES - 1);
   localparam logic [31:0] SPEED_LD = 32'(SPEED_CYCLES - 1);
   localparam logic [31:0] WIN_LD   = 32'(WIN_STEP_CYCLES - 1);

   state_t      state;
   logic [31:0] dur;
   logic [1:0]  step;

   logic        any_evt;
   logic [1:0]  lvl;
   logic [31:0] lvl_ld;
   logic        accept;
   logic [1:0]  step_nxt;

   // Level code doubles as the sound code; win is highest.
   always_comb begin
      any_evt = right_evt | left_evt | speed_evt | win_evt;
      lvl     = 2'd0;
      if (win_evt)        lvl = 2'd3;
      else if (speed_evt) lvl = 2'd2;
      else if (left_evt)  lvl = 2'd1;
      lvl_ld = BTN_LD;
      case (lvl)
         2'd3:    lvl_ld = WIN_LD;
         2'd2:    lvl_ld = SPEED_LD;
         default: lvl_ld = BTN_LD;
      endcase
      // While playing, only an equal or higher level may retrigger/preempt.
      accept = any_evt && ((state == IDLE) ||
                           (state == PLAY && lvl >= sound_type));
      step_nxt = step + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dur        <= '0;
         step       <= '0;
         sound_type <= 2'd0;
         sound_en   <= 1'b0;
         busy       <= 1'b0;
      end else if (game_restart) begin
         state    <= IDLE;
         step     <= '0;
         sound_en <= 1'b0;
         busy     <= 1'b0;
      end else if (accept) begin
         state      <= (lvl == 2'd3) ? WIN_SEQ : PLAY;
         dur        <= lvl_ld;
         step       <= '0;
         sound_type <= lvl;
         sound_en   <= 1'b1;
         busy       <= 1'b1;
      end else begin
         case (state)
            PLAY: begin
               if (dur == '0) begin
                  state    <= IDLE;
                  sound_en <= 1'b0;
                  busy     <= 1'b0;
               end else begin
                  dur <= dur - 32'd1;
               end
            end
            WIN_SEQ: begin
               if (dur != '0) begin
                  dur <= dur - 32'd1;
               end else if (step == 2'd3) begin
                  state    <= LOCKED;
                  sound_en <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  // Melody alternates 3,2,3,2: odd steps play the speed tone.
                  step       <= step_nxt;
                  dur        <= WIN_LD;
                  sound_type <= step_nxt[0] ? 2'd2 : 2'd3;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench for sound_event_sequencer with short durations
// (BTN=4, SPEED=8, WIN_STEP=3); expected values are hand-derived.
module tb_sound_event_sequencer;

   localparam logic [4:0] EV_R = 5'b00001;
   localparam logic [4:0] EV_L = 5'b00010;
   localparam logic [4:0] EV_S = 5'b00100;
   localparam logic [4:0] EV_W = 5'b01000;
   localparam logic [4:0] EV_G = 5'b10000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       right_evt = 1'b0, left_evt = 1'b0, speed_evt = 1'b0;
   logic       win_evt = 1'b0, game_restart = 1'b0;
   logic [1:0] sound_type;
   logic       sound_en, busy;

   int total = 0;
   int bad   = 0;

   sound_event_sequencer #(
      .BTN_CYCLES(4), .SPEED_CYCLES(8), .WIN_STEP_CYCLES(3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .right_evt(right_evt), .left_evt(left_evt), .speed_evt(speed_evt),
      .win_evt(win_evt), .game_restart(game_restart),
      .sound_type(sound_type), .sound_en(sound_en), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // At a falling edge: check outputs of the previous rising edge, then drive
   // the events sampled by the next rising edge and advance one cycle.
   task automatic cyc(input logic [4:0] ev, input logic en, input logic [1:0] ty,
                      input logic bz, input string tag);
      chk({tag, ".en"}, 32'(sound_en), 32'(en));
      if (en) chk({tag, ".type"}, 32'(sound_type), 32'(ty));
      chk({tag, ".busy"}, 32'(busy), 32'(bz));
      {game_restart, win_evt, speed_evt, left_evt, right_evt} = ev;
      @(negedge clk);
      {game_restart, win_evt, speed_evt, left_evt, right_evt} = 5'b0;
   endtask

   logic [1:0] melody [12] = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2,
                               2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2};

   initial begin
      // Reset held with an event pending: outputs must stay quiet.
      right_evt = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst.type", 32'(sound_type), 32'd0);
         chk("rst.en",   32'(sound_en),   32'd0);
         chk("rst.busy", 32'(busy),       32'd0);
      end
      right_evt = 1'b0;
      rst_n = 1'b1;

      // First cycle after release: right sound for exactly 4 cycles.
      cyc(EV_R, 0, 0, 0, "idle");
      repeat (4) cyc(0, 1, 0, 1, "btn");
      cyc(0, 0, 0, 0, "btn_end");

      // Simultaneous left+speed: speed wins.
      cyc(EV_L | EV_S, 0, 0, 0, "sim");
      repeat (8) cyc(0, 1, 2, 1, "sim_spd");
      cyc(0, 0, 0, 0, "sim_end");

      // Lower level ignored.
      cyc(EV_L, 0, 0, 0, "ign");
      cyc(0, 1, 1, 1, "ign1");
      cyc(EV_R, 1, 1, 1, "ign2");
      repeat (2) cyc(0, 1, 1, 1, "ign_tail");
      cyc(0, 0, 0, 0, "ign_end");

      // Higher level preempts.
      cyc(EV_L, 0, 0, 0, "pre");
      cyc(0, 1, 1, 1, "pre1");
      cyc(EV_S, 1, 1, 1, "pre2");
      repeat (8) cyc(0, 1, 2, 1, "pre_spd");
      cyc(0, 0, 0, 0, "pre_end");

      // Retrigger in the last active cycle: 8 continuous cycles.
      cyc(EV_R, 0, 0, 0, "rtg");
      repeat (3) cyc(0, 1, 0, 1, "rtg_a");
      cyc(EV_R, 1, 0, 1, "rtg_last");
      repeat (4) cyc(0, 1, 0, 1, "rtg_b");
      cyc(0, 0, 0, 0, "rtg_end");

      // Win melody, lock, ignore, restart.
      cyc(EV_W, 0, 0, 0, "win");
      for (int i = 0; i < 12; i++) cyc(0, 1, melody[i], 1, $sformatf("mel%0d", i));
      cyc(0, 0, 0, 1, "lock");
      cyc(EV_L, 0, 0, 1, "lock_evt");
      cyc(0, 0, 0, 1, "lock_ign");
      cyc(EV_G, 0, 0, 1, "lock_rst");
      cyc(EV_L, 0, 0, 0, "unlock");
      repeat (4) cyc(0, 1, 1, 1, "post_left");
      cyc(0, 0, 0, 0, "post_end");

      // Restart beats win in the same cycle.
      cyc(EV_G | EV_W, 0, 0, 0, "gw");
      cyc(0, 0, 0, 0, "gw1");
      cyc(0, 0, 0, 0, "gw2");

      // Asynchronous reset mid-sound silences without a clock edge.
      cyc(EV_S, 0, 0, 0, "ares");
      repeat (2) cyc(0, 1, 2, 1, "ares_spd");
      #1 rst_n = 1'b0;
      #1;
      chk("ares.en",   32'(sound_en),   32'd0);
      chk("ares.busy", 32'(busy),       32'd0);
      chk("ares.type", 32'(sound_type), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, "after_ares");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
